// File: rtl/pq_arbiter.sv
// pq_arbiter: round-robin arbiter sharing one priority-queue device among
// N_REQ clients. Only one enq/deq/replace operation is in flight at a time.
// Each operation is gated against the device's busy/full/empty status. For
// DEQ and REPLACE, the head item seen at issue time is returned to the winner.
//
// Optional feature: define PQ_ARB_STATS_EN to add two saturating 32-bit
// counters, stat_ops and stat_stall.
//
// Operation flow: IDLE -> ISSUE -> SETTLE -> IDLE.
//   IDLE   arbitrate and register the strobes.
//   ISSUE  strobes are high for this cycle; capture the pre-op head.
//   SETTLE one-cycle grant pulse; the device has time to raise busy.

module pq_arbiter #(
  parameter int N_REQ = 4,
  parameter int KV_W  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [2*N_REQ-1:0]      op,
  input  logic [N_REQ*KV_W-1:0]   kvi,
  output logic [N_REQ-1:0]        gnt,
  output logic [KV_W-1:0]         kvo,
  output logic                    pq_enq,
  output logic                    pq_deq,
  output logic [KV_W-1:0]         pq_kvi,
  input  logic [KV_W-1:0]         pq_kvo,
  input  logic                    pq_busy,
  input  logic                    pq_full,
  input  logic                    pq_empty
`ifdef PQ_ARB_STATS_EN
  ,
  output logic [31:0]             stat_ops,
  output logic [31:0]             stat_stall
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] OP_ENQ  = 2'b01;
  localparam logic [1:0] OP_DEQ  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE  = 2'b01,
    SETTLE = 2'b10
  } state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  rrPtr_r;
  logic [IDX_W-1:0]  winner_r;

  logic [N_REQ-1:0]  eligible_s;
  logic              found_s;
  logic [IDX_W-1:0]  winner_s;
  logic [1:0]        opWin_s;
  logic [KV_W-1:0]   kviWin_s;
  logic              issue_s;
  logic [IDX_W-1:0]  rrNext_s;

  // Index that follows idx, wrapping from the last client back to client 0.
  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] res;
    if (idx == LAST_IDX) begin
      res = '0;
    end else begin
      res = idx + IDX_W'(1);
    end
    return res;
  endfunction

  // Per-client eligibility: a valid op whose precondition on the device holds.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      case (op[2*i +: 2])
        OP_ENQ:          eligible_s[i] = req[i] & ~pq_full;
        OP_DEQ, OP_REPL: eligible_s[i] = req[i] & ~pq_empty;
        default:         eligible_s[i] = 1'b0;
      endcase
    end
  end

  // Rotating search: first eligible client at or above rrPtr_r, with wrap.
  always_comb begin
    int cand;
    found_s  = 1'b0;
    winner_s = '0;
    cand     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rrPtr_r) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end else begin
        cand = cand;
      end
      if (!found_s && eligible_s[cand]) begin
        found_s  = 1'b1;
        winner_s = IDX_W'(cand);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Operands of the winning client and the issue decision for this cycle.
  always_comb begin
    opWin_s  = op[2*winner_s +: 2];
    kviWin_s = kvi[winner_s*KV_W +: KV_W];
    issue_s  = (state_r == IDLE) & ~pq_busy & found_s;
    rrNext_s = nextIdx(winner_r);
  end

  // Operation sequencer; every device-facing and client-facing output is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      rrPtr_r  <= '0;
      winner_r <= '0;
      gnt      <= '0;
      kvo      <= '0;
      pq_enq   <= 1'b0;
      pq_deq   <= 1'b0;
      pq_kvi   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          gnt <= '0;
          if (issue_s) begin
            pq_enq   <= opWin_s[0];
            pq_deq   <= opWin_s[1];
            pq_kvi   <= kviWin_s;
            winner_r <= winner_s;
            state_r  <= ISSUE;
          end else begin
            pq_enq   <= 1'b0;
            pq_deq   <= 1'b0;
            state_r  <= IDLE;
          end
        end
        ISSUE: begin
          // The device acts on the strobes at this edge, so pq_kvo is still the pre-op head.
          pq_enq  <= 1'b0;
          pq_deq  <= 1'b0;
          kvo     <= pq_kvo;
          gnt     <= ONE_HOT0 << winner_r;
          state_r <= SETTLE;
        end
        SETTLE: begin
          gnt     <= '0;
          rrPtr_r <= rrNext_s;
          state_r <= IDLE;
        end
        default: begin
          gnt     <= '0;
          pq_enq  <= 1'b0;
          pq_deq  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef PQ_ARB_STATS_EN
  // Saturating counters: granted ops, and idle cycles where requests waited.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ops   <= 32'h0000_0000;
      stat_stall <= 32'h0000_0000;
    end else begin
      if ((state_r == SETTLE) && (stat_ops != 32'hFFFF_FFFF)) begin
        stat_ops <= stat_ops + 32'h0000_0001;
      end else begin
        stat_ops <= stat_ops;
      end
      if ((state_r == IDLE) && (|req) && !issue_s && (stat_stall != 32'hFFFF_FFFF)) begin
        stat_stall <= stat_stall + 32'h0000_0001;
      end else begin
        stat_stall <= stat_stall;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pq_arbiter.sv
// Directed bench for pq_arbiter, with a small behavioural priority-queue device.
module tb_pq_arbiter;

  localparam int N   = 4;
  localparam int KW  = 64;
  localparam int CAP = 8;

  localparam logic [1:0] ENQ  = 2'b01;
  localparam logic [1:0] DEQ  = 2'b10;
  localparam logic [1:0] REPL = 2'b11;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [2*N-1:0]  op;
  logic [N*KW-1:0] kvi;
  logic [N-1:0]    gnt;
  logic [KW-1:0]   kvo;
  logic            pq_enq;
  logic            pq_deq;
  logic [KW-1:0]   pq_kvi;
  logic [KW-1:0]   pq_kvo;
  logic            pq_busy;
  logic            pq_full;
  logic            pq_empty;

  int nVec = 0;
  int nErr = 0;

  // Device model state
  logic [KW-1:0] mem [CAP];
  int            cnt = 0;
  int            minIdx;
  logic          devClear;
  logic          devBusy;

  pq_arbiter #(.N_REQ(N), .KV_W(KW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .kvi(kvi),
    .gnt(gnt), .kvo(kvo), .pq_enq(pq_enq), .pq_deq(pq_deq),
    .pq_kvi(pq_kvi), .pq_kvo(pq_kvo), .pq_busy(pq_busy),
    .pq_full(pq_full), .pq_empty(pq_empty)
  );

  always #5 clk = ~clk;

  // Device head: smallest stored item.
  always_comb begin
    minIdx = 0;
    for (int i = 1; i < CAP; i++) begin
      if (i < cnt && mem[i] < mem[minIdx]) minIdx = i;
    end
  end

  assign pq_kvo   = (cnt == 0) ? 64'd0 : mem[minIdx];
  assign pq_full  = (cnt == CAP);
  assign pq_empty = (cnt == 0);
  assign pq_busy  = devBusy;

  // Device update: enq inserts, deq removes head, both together replace the head.
  always @(posedge clk) begin
    if (devClear) begin
      cnt <= 0;
    end else if (pq_enq && pq_deq) begin
      if (cnt > 0) mem[minIdx] <= pq_kvi;
    end else if (pq_deq) begin
      if (cnt > 0) begin
        mem[minIdx] <= mem[cnt-1];
        cnt <= cnt - 1;
      end
    end else if (pq_enq) begin
      if (cnt < CAP) begin
        mem[cnt] <= pq_kvi;
        cnt <= cnt + 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int c, input logic [1:0] o, input logic [63:0] k);
    req[c]           = 1'b1;
    op[2*c +: 2]     = o;
    kvi[c*KW +: KW]  = k;
  endtask

  task automatic dropReq(input int c);
    req[c]       = 1'b0;
    op[2*c +: 2] = 2'b00;
  endtask

  // One operation for a single client: wait (bounded) for its grant, then release.
  task automatic doOp(input int c, input logic [1:0] o, input logic [63:0] k,
                      input logic chkKvo, input logic [63:0] expKvo, input string tag);
    int n;
    logic [N-1:0] e;
    e = 4'b0001 << c;
    setReq(c, o, k);
    n = 0;
    do begin
      step(1);
      n++;
    end while (gnt == 4'b0000 && n < 20);
    check({tag, "_gnt"}, 64'(gnt), 64'(e));
    if (chkKvo) check({tag, "_kvo"}, kvo, expKvo);
    dropReq(c);
    step(1);
  endtask

  logic [N-1:0] ord [5];

  initial begin
    ord[0] = 4'b0001; ord[1] = 4'b0010; ord[2] = 4'b0100;
    ord[3] = 4'b1000; ord[4] = 4'b0001;
    rst = 1'b0; req = '0; op = '0; kvi = '0;
    devClear = 1'b1; devBusy = 1'b0;
    step(2);
    // Reset state
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_kvo", kvo, 64'd0);
    check("rst_enq", 64'(pq_enq), 64'd0);
    check("rst_deq", 64'(pq_deq), 64'd0);
    check("rst_kvi", pq_kvi, 64'd0);
    rst = 1'b1; devClear = 1'b0;
    step(1);

    // Test 1: client 1 ENQ key 5; strobe at t+1, grant at t+2
    setReq(1, ENQ, 64'd5);
    check("t1_enq_t0", 64'(pq_enq), 64'd0);
    step(1);
    check("t1_enq_t1", 64'(pq_enq), 64'd1);
    check("t1_deq_t1", 64'(pq_deq), 64'd0);
    check("t1_kvi_t1", pq_kvi, 64'd5);
    check("t1_gnt_t1", 64'(gnt), 64'd0);
    step(1);
    check("t1_enq_t2", 64'(pq_enq), 64'd0);
    check("t1_gnt_t2", 64'(gnt), 64'(4'b0010));
    dropReq(1);
    step(1);
    check("t1_gnt_t3", 64'(gnt), 64'd0);

    // Test 2: fill the device (5,9,3,8,12,20,15,6), then contend ENQ vs DEQ
    doOp(0, ENQ, 64'd9,  1'b0, 64'd0, "fill1");
    doOp(0, ENQ, 64'd3,  1'b0, 64'd0, "fill2");
    doOp(0, ENQ, 64'd8,  1'b0, 64'd0, "fill3");
    doOp(0, ENQ, 64'd12, 1'b0, 64'd0, "fill4");
    doOp(0, ENQ, 64'd20, 1'b0, 64'd0, "fill5");
    doOp(0, ENQ, 64'd15, 1'b0, 64'd0, "fill6");
    doOp(0, ENQ, 64'd6,  1'b0, 64'd0, "fill7");
    setReq(0, ENQ, 64'd1);
    setReq(2, DEQ, 64'd0);
    step(1);
    check("t2_deq", 64'(pq_deq), 64'd1);
    check("t2_enq", 64'(pq_enq), 64'd0);
    step(1);
    check("t2_gnt2", 64'(gnt), 64'(4'b0100));
    check("t2_kvo", kvo, 64'd3);
    dropReq(2);
    step(1);
    check("t2_gap", 64'(gnt), 64'd0);
    step(1);
    check("t2_enq0", 64'(pq_enq), 64'd1);
    check("t2_kvi0", pq_kvi, 64'd1);
    step(1);
    check("t2_gnt0", 64'(gnt), 64'(4'b0001));
    dropReq(0);
    step(1);

    // Drain two heads: 1 then 5
    doOp(1, DEQ, 64'd0, 1'b1, 64'd1, "drain1");
    doOp(1, DEQ, 64'd0, 1'b1, 64'd5, "drain2");

    // Test 4: empty device; REPLACE waits until another client enqueues
    devClear = 1'b1;
    step(1);
    devClear = 1'b0;
    setReq(3, REPL, 64'd7);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t4_blocked", 64'({pq_enq, pq_deq, gnt}), 64'd0);
    end
    doOp(1, ENQ, 64'd2, 1'b0, 64'd0, "t4_enq1");
    step(1);
    check("t4_repl_str", 64'({pq_enq, pq_deq}), 64'(2'b11));
    check("t4_repl_kvi", pq_kvi, 64'd7);
    step(1);
    check("t4_gnt3", 64'(gnt), 64'(4'b1000));
    check("t4_kvo", kvo, 64'd2);
    dropReq(3);
    step(1);

    // Test 3: all clients ENQ continuously; order 0,1,2,3,0, pulses 3 cycles apart
    setReq(0, ENQ, 64'd10);
    setReq(1, ENQ, 64'd11);
    setReq(2, ENQ, 64'd12);
    setReq(3, ENQ, 64'd13);
    step(2);
    check("t3_gnt_0", 64'(gnt), 64'(ord[0]));
    for (int k = 1; k < 5; k++) begin
      step(1);
      check("t3_gap", 64'(gnt), 64'd0);
      step(2);
      check("t3_gnt_k", 64'(gnt), 64'(ord[k]));
    end
    req = '0; op = '0;
    step(1);

    // Test 5: busy held 10 cycles blocks issue; first strobe 1 cycle after busy falls
    devBusy = 1'b1;
    setReq(2, ENQ, 64'd30);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("t5_busy", 64'({pq_enq, pq_deq, gnt}), 64'd0);
    end
    devBusy = 1'b0;
    check("t5_fall", 64'(pq_enq), 64'd0);
    step(1);
    check("t5_issue", 64'(pq_enq), 64'd1);
    check("t5_kvi", pq_kvi, 64'd30);
    step(1);
    check("t5_gnt", 64'(gnt), 64'(4'b0100));
    dropReq(2);
    step(1);

    // Test 6: reset during ISSUE abandons the op; arbitration restarts at client 0
    setReq(0, ENQ, 64'd40);
    step(1);
    check("t6_issue", 64'(pq_enq), 64'd1);
    #2;
    rst = 1'b0; devClear = 1'b1;
    req = '0; op = '0;
    #1;
    check("t6_rst_str", 64'({pq_enq, pq_deq}), 64'd0);
    check("t6_rst_gnt", 64'(gnt), 64'd0);
    check("t6_rst_kvo", kvo, 64'd0);
    check("t6_rst_kvi", pq_kvi, 64'd0);
    step(1);
    rst = 1'b1; devClear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t6_nognt", 64'({pq_enq, pq_deq, gnt}), 64'd0);
    end
    setReq(0, ENQ, 64'd41);
    setReq(3, ENQ, 64'd43);
    step(2);
    check("t6_first", 64'(gnt), 64'(4'b0001));
    dropReq(0);
    step(3);
    check("t6_second", 64'(gnt), 64'(4'b1000));
    dropReq(3);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
